sad_row_scheduler: RTL and testbench

Sequencer for the SAD processor's row line-buffer RAM (ROWS entries, one image row each, sequential write, registered read address with data valid one cycle after the address is sampled). It clears the RAM, loads one frame of rows from an upstream valid/ready stream, and then sweeps overlapping vertical windows over the stored rows. Each read beat goes to the downstream SAD engine under valid/ready backpressure, with window-start and window-end markers.

---
 rtl/sad_row_scheduler.sv | 151 +++++++++++++++
 tb/tb_sad_row_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_row_scheduler.sv
// Row line-buffer sequencer for the SAD processor: clears the RAM, loads one frame of rows,
// then sweeps overlapping vertical windows out to the SAD engine under valid/ready.
module sad_row_scheduler #(
   parameter int unsigned ROWS   = 480,
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned WIN    = 8,
   parameter int unsigned STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic              o_ram_rst,
   output logic              o_ram_wr_en,
   input  logic              i_ram_full,
   output logic [ADDR_W-1:0] o_ram_read_addr,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [ADDR_W-1:0] o_out_row,
   output logic              o_out_first,
   output logic              o_out_last,
   output logic              o_busy,
   output logic              o_frame_done
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StLoad,
      StSweep,
      StDrain,
      StDone
   } state_t;

   localparam logic [ADDR_W-1:0] LP_ROWS    = ADDR_W'(ROWS);
   localparam logic [ADDR_W-1:0] LP_ROWS_M1 = ADDR_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] LP_WIN_M1  = ADDR_W'(WIN - 1);
   localparam logic [ADDR_W-1:0] LP_LAST_B  = ADDR_W'(ROWS - WIN);
   localparam logic [ADDR_W-1:0] LP_STRIDE  = ADDR_W'(STRIDE);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_load_cnt;
   logic [ADDR_W-1:0]   r_b;
   logic [ADDR_W-1:0]   r_k;
   logic                r_out_valid;
   logic [ADDR_W-1:0]   r_out_row;
   logic                r_out_first;
   logic                r_out_last;
   logic                r_frame_done;

   logic [ADDR_W-1:0]   w_p;
   logic                w_advance;
   logic                w_in_ready;
   logic                w_wr_en;
   logic                w_hold_addr;

   assign w_p        = r_b + r_k;
   assign w_advance  = !r_out_valid || i_out_ready;
   assign w_in_ready = !rst && (r_state == StLoad) && (r_load_cnt < LP_ROWS) && !i_ram_full;
   assign w_wr_en    = i_in_valid && w_in_ready;

   // A presented beat that is not being replaced keeps its address so RAM data_out stays put.
   assign w_hold_addr = r_out_valid && !((r_state == StSweep) && i_out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_load_cnt   <= '0;
         r_b          <= '0;
         r_k          <= '0;
         r_out_valid  <= 1'b0;
         r_out_row    <= '0;
         r_out_first  <= 1'b0;
         r_out_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_state <= StClear;
               end
            end
            StClear: begin
               r_load_cnt  <= '0;
               r_b         <= '0;
               r_k         <= '0;
               r_out_valid <= 1'b0;
               r_out_first <= 1'b0;
               r_out_last  <= 1'b0;
               r_state     <= StLoad;
            end
            StLoad: begin
               if (w_wr_en) begin
                  r_load_cnt <= r_load_cnt + 1'b1;
                  if (r_load_cnt == LP_ROWS_M1) begin
                     r_state <= StSweep;
                  end
               end
            end
            StSweep: begin
               if (w_advance) begin
                  r_out_valid <= 1'b1;
                  r_out_row   <= w_p;
                  r_out_first <= (r_k == '0);
                  r_out_last  <= (r_k == LP_WIN_M1);
                  if (r_k == LP_WIN_M1) begin
                     // Counters stay on the final beat so they never step past the frame.
                     if (r_b == LP_LAST_B) begin
                        r_state <= StDrain;
                     end else begin
                        r_k <= '0;
                        r_b <= r_b + LP_STRIDE;
                     end
                  end else begin
                     r_k <= r_k + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (w_advance) begin
                  r_out_valid  <= 1'b0;
                  r_out_first  <= 1'b0;
                  r_out_last   <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_state      <= StDone;
               end
            end
            StDone: begin
               r_frame_done <= 1'b0;
               r_state      <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_in_ready      = w_in_ready;
   assign o_ram_wr_en     = w_wr_en;
   assign o_ram_rst       = rst || (r_state == StClear);
   assign o_ram_read_addr = rst ? '0 : (w_hold_addr ? r_out_row : w_p);
   assign o_out_valid     = r_out_valid && !rst;
   assign o_out_row       = rst ? '0 : r_out_row;
   assign o_out_first     = r_out_first && !rst;
   assign o_out_last      = r_out_last && !rst;
   assign o_frame_done    = r_frame_done && !rst;
   assign o_busy          = (r_state != StIdle);

endmodule

// File: tb/tb_sad_row_scheduler.sv
// Randomized bench for sad_row_scheduler: a RAM stand-in plus an arithmetic beat-order model.
module tb_sad_row_scheduler;
   localparam int unsigned ROWS   = 16;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned WIN    = 4;
   localparam int unsigned STRIDE = 2;
   localparam int unsigned NWIN   = (ROWS - WIN) / STRIDE + 1;
   localparam int unsigned NBEATS = NWIN * WIN;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1, start = 1'b0, in_valid = 1'b0, ram_full = 1'b0;
   logic              out_ready = 1'b0;
   logic              in_ready, ram_rst, ram_wr_en, out_valid, out_first, out_last;
   logic              busy, frame_done;
   logic [ADDR_W-1:0] ram_read_addr, out_row;

   logic              b_start = 1'b0;
   logic              b_in_ready, b_ram_rst, b_wr_en, b_out_valid, b_out_first, b_out_last;
   logic              b_busy, b_frame_done;
   logic [ADDR_W-1:0] b_addr, b_out_row;

   sad_row_scheduler #(.ROWS(ROWS), .ADDR_W(ADDR_W), .WIN(WIN), .STRIDE(STRIDE)) u_dut (
      .clk(clk), .rst(rst), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .o_ram_rst(ram_rst), .o_ram_wr_en(ram_wr_en), .i_ram_full(ram_full),
      .o_ram_read_addr(ram_read_addr), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_row(out_row), .o_out_first(out_first), .o_out_last(out_last), .o_busy(busy),
      .o_frame_done(frame_done)
   );

   sad_row_scheduler #(.ROWS(ROWS), .ADDR_W(ADDR_W), .WIN(ROWS), .STRIDE(1)) u_dut_full (
      .clk(clk), .rst(rst), .i_start(b_start), .i_in_valid(1'b1), .o_in_ready(b_in_ready),
      .o_ram_rst(b_ram_rst), .o_ram_wr_en(b_wr_en), .i_ram_full(1'b0),
      .o_ram_read_addr(b_addr), .o_out_valid(b_out_valid), .i_out_ready(1'b1),
      .o_out_row(b_out_row), .o_out_first(b_out_first), .o_out_last(b_out_last),
      .o_busy(b_busy), .o_frame_done(b_frame_done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_row(input int i);
      return (i / WIN) * STRIDE + (i % WIN);
   endfunction

   function automatic logic [15:0] row_val(input int r);
      return 16'(r * 305 + 165);
   endfunction

   // RAM stand-in: sequential write, registered read, cleared by ram_rst.
   logic [15:0] mem [ROWS];
   int          wp = 0;
   logic [15:0] rd_q;
   logic [15:0] in_data;
   always_comb in_data = row_val(wp);
   always @(posedge clk) begin
      if (ram_rst) begin
         for (int i = 0; i < ROWS; i++) mem[i] <= '0;
         wp <= 0;
      end else if (ram_wr_en) begin
         if (wp < ROWS) mem[wp] <= in_data;
         wp <= wp + 1;
      end
      rd_q <= mem[ram_read_addr];
   end

   bit rand_ready = 0, rand_gaps = 0, rand_full = 0;
   initial forever begin
      @(posedge clk); #1;
      in_valid  = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      ram_full  = rand_full ? ($urandom_range(0, 7) == 0) : 1'b0;
   end

   int          idx = 0, n_wr = 0, cyc = 0, last_xfer = 0, frames = 0, firsts = 0, lasts = 0;
   int          rows_seen [NBEATS];
   bit          stalled = 0;
   logic [15:0] held_data;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
         chk("rst_ram_rst", ram_rst, 1);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_read_addr", ram_read_addr, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_b_addr", b_addr, 0);
         chk("rst_b_ram_rst", b_ram_rst, 1);
         idx = 0; n_wr = 0; stalled = 0; firsts = 0; lasts = 0;
      end else begin
         if (ram_rst) begin
            idx = 0; n_wr = 0; stalled = 0; firsts = 0; lasts = 0;
         end
         if (n_wr >= ROWS) chk("in_ready_after_load", in_ready, 0);
         if (ram_wr_en) begin
            chk("wr_needs_valid", in_valid, 1);
            chk("wr_while_full", ram_full, 0);
            chk("wr_during_read", out_valid, 0);
            n_wr++;
         end
         if (out_valid) begin
            chk("valid_after_load", n_wr, ROWS);
            if (idx < NBEATS) begin
               chk("beat_row", out_row, exp_row(idx));
               chk("beat_first", out_first, (idx % WIN) == 0);
               chk("beat_last", out_last, (idx % WIN) == WIN - 1);
               chk("beat_data", rd_q, row_val(exp_row(idx)));
               if (stalled) chk("stall_data", rd_q, held_data);
            end else begin
               checks++;
               errors++;
               $display("FAIL beat_overrun: got beat %0d expected at most %0d", idx + 1, NBEATS);
            end
            stalled   = !out_ready;
            held_data = rd_q;
            if (out_ready) begin
               if (idx < NBEATS) rows_seen[idx] = int'(out_row);
               firsts += int'(out_first);
               lasts  += int'(out_last);
               last_xfer = cyc;
               idx++;
            end
         end else begin
            stalled = 0;
         end
         if (frame_done) begin
            chk("done_beats", idx, NBEATS);
            chk("done_latency", cyc - last_xfer, 1);
            chk("done_writes", n_wr, ROWS);
            frames++;
         end
      end
   end

   int b_rows [$];
   bit b_f [$];
   bit b_l [$];
   int b_nwr = 0;
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (b_out_valid) begin
            b_rows.push_back(int'(b_out_row));
            b_f.push_back(b_out_first);
            b_l.push_back(b_out_last);
         end
         if (b_wr_en) b_nwr++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (!frame_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!frame_done) begin
         checks++;
         errors++;
         $display("FAIL frame_done_timeout: got none expected within %0d cycles", bound);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_frames;
      exp_frames = 0;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_out_row", out_row, 0);
      chk("reset_read_addr", ram_read_addr, 0);
      chk("reset_wr_en", ram_wr_en, 0);
      chk("reset_ram_rst", ram_rst, 0);
      chk("reset_first_last", {out_first, out_last}, 0);
      tick();

      // Directed frame: continuous input, no backpressure, with cycle-exact timing.
      pulse_start();
      @(negedge clk);
      chk("clear_ram_rst", ram_rst, 1);
      chk("clear_busy", busy, 1);
      chk("clear_in_ready", in_ready, 0);
      tick();
      @(negedge clk);
      chk("load_ram_rst", ram_rst, 0);
      chk("load_in_ready", in_ready, 1);
      wait_done(200, n);
      chk("done_cycle", n, 45);
      chk("done_busy", busy, 1);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_frame_done", frame_done, 0);
      tick();
      exp_frames++;
      chk("dir_frames", frames, exp_frames);
      chk("dir_beats", idx, 28);
      chk("dir_writes", n_wr, 16);
      chk("dir_row4", rows_seen[4], 2);
      chk("dir_row7", rows_seen[7], 5);
      chk("dir_row27", rows_seen[27], 15);
      chk("dir_firsts", firsts, 7);
      chk("dir_lasts", lasts, 7);

      // Random backpressure, input gaps, full flag, and ignored start pulses.
      for (int f = 0; f < 3; f++) begin
         rand_ready = 1; rand_gaps = 1; rand_full = 1;
         pulse_start();
         repeat (5) tick();
         chk("load_start_busy", busy, 1);
         pulse_start();
         n = 0;
         while (!out_valid && n < 300) begin tick(); n++; end
         pulse_start();
         wait_done(2000, n);
         tick();
         exp_frames++;
         chk("rnd_frames", frames, exp_frames);
         chk("rnd_beats", idx, NBEATS);
         repeat (3) tick();
         chk("rnd_idle", busy, 0);
      end

      // Reset mid-sweep, then a clean frame.
      rand_gaps = 0; rand_full = 0; rand_ready = 1;
      pulse_start();
      n = 0;
      while (idx <= 10 && n < 500) begin tick(); n++; end
      chk("mid_reached", idx > 10, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ram_rst", ram_rst, 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_row", out_row, 0);
      chk("post_rst_done", frame_done, 0);
      tick();
      chk("abort_no_frame", frames, exp_frames);
      pulse_start();
      wait_done(2000, n);
      tick();
      exp_frames++;
      chk("fresh_frames", frames, exp_frames);
      chk("fresh_beats", idx, NBEATS);

      // Single window spanning the whole frame.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      n = 0;
      while (!b_frame_done && n < 200) begin tick(); n++; end
      chk("full_done_seen", b_frame_done, 1);
      tick();
      chk("full_beats", b_rows.size(), 16);
      chk("full_writes", b_nwr, 16);
      chk("full_busy", b_busy, 0);
      for (int i = 0; i < b_rows.size() && i < 16; i++) begin
         chk("full_row", b_rows[i], i);
         chk("full_first", b_f[i], i == 0);
         chk("full_last", b_l[i], i == 15);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
